// File: rtl/load_store_unit.sv
// Purpose : load/store front end for a byte-addressed, big-endian 32-bit data memory.
// Latency : request accepted at edge N drives memory in cycle N..N+1; response valid after edge N+1.
// Backpr. : req_ready only in IDLE; response held stable in RESP until resp_ready.
//
// Optional feature macro: MISALIGN_TRAP_EN (fault on misaligned half/word accesses).
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_size, req_unsigned  store flag, size (00 b, 01 h, 10 w, 11 illegal), zero-extend flag
//   req_addr, req_wdata             byte address, right-aligned store data
//   resp_valid/resp_ready           response handshake
//   resp_rdata, resp_fault          extended load data (0 for stores/faults), fault flag
//   mem_address, mem_mask           byte address, byte-lane overwrite mask (lane 0 = [31:24])
//   mem_wf, mem_w, mem_v            write flag, write data, combinational read data
module load_store_unit #(
  parameter int M = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_fault,
  output logic [M+1:0]  mem_address,
  output logic [31:0]   mem_mask,
  output logic          mem_wf,
  output logic [31:0]   mem_w,
  input  logic [31:0]   mem_v
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam logic [32:0] MEM_BYTES = 33'd4 << M;

  state_t       state, state_nxt;

  logic         we_q;
  logic [1:0]   size_q;
  logic         uns_q;
  logic [31:0]  addr_q;
  logic [31:0]  wdata_q;

  logic         in_access;
  logic [32:0]  nbytes;
  logic [32:0]  end_addr;
  logic         range_fault;
  logic         misalign_fault;
  logic         fault;
  logic [31:0]  lane_mask;
  logic [31:0]  lane_w;
  logic [31:0]  load_ext;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign in_access  = (state == ACCESS);

  // ---------------- request capture ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (req_valid && req_ready) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // ---------------- fault decode ----------------
  always_comb begin
    nbytes = 33'd0;
    case (size_q)
      2'b00:   nbytes = 33'd1;
      2'b01:   nbytes = 33'd2;
      2'b10:   nbytes = 33'd4;
      default: nbytes = 33'd0;
    endcase
  end

  // 33-bit sum so an access near 2^32 cannot wrap back into range.
  assign end_addr    = {1'b0, addr_q} + nbytes;
  assign range_fault = (end_addr > MEM_BYTES);

`ifdef MISALIGN_TRAP_EN
  assign misalign_fault = ((size_q == 2'b01) && addr_q[0]) ||
                          ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign_fault = 1'b0;
`endif

  assign fault = (size_q == 2'b11) || range_fault || misalign_fault;

  // ---------------- memory port (decoded from state) ----------------
  always_comb begin
    lane_mask = 32'h0;
    lane_w    = 32'h0;
    case (size_q)
      2'b00: begin
        lane_mask = 32'hFF00_0000;
        lane_w    = {wdata_q[7:0], 24'h0};
      end
      2'b01: begin
        lane_mask = 32'hFFFF_0000;
        lane_w    = {wdata_q[15:0], 16'h0};
      end
      2'b10: begin
        lane_mask = 32'hFFFF_FFFF;
        lane_w    = wdata_q;
      end
      default: begin
        lane_mask = 32'h0;
        lane_w    = 32'h0;
      end
    endcase
  end

  // Purely combinational from state so a reset in ACCESS kills the write at once.
  assign mem_address = in_access ? addr_q[M+1:0] : '0;
  assign mem_mask    = (in_access && !fault) ? lane_mask : 32'h0;
  assign mem_w       = (in_access && !fault) ? lane_w : 32'h0;
  assign mem_wf      = in_access && we_q && !fault;

  // ---------------- load extraction ----------------
  // The addressed byte always arrives in [31:24], so extraction is from the top.
  always_comb begin
    load_ext = 32'h0;
    case (size_q)
      2'b00:   load_ext = {{24{!uns_q && mem_v[31]}}, mem_v[31:24]};
      2'b01:   load_ext = {{16{!uns_q && mem_v[31]}}, mem_v[31:16]};
      2'b10:   load_ext = mem_v;
      default: load_ext = 32'h0;
    endcase
  end

  // ---------------- response registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= 32'h0;
      resp_fault <= 1'b0;
    end else if (in_access) begin
      resp_rdata <= (fault || we_q) ? 32'h0 : load_ext;
      resp_fault <= fault;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose : directed, table-driven check of load_store_unit against a byte-array memory model.
// Latency : one request per transaction; expects response after edge N+1 of accept edge N.
// Backpr. : exercises resp_ready stall and reset in the middle of a store.
module tb_load_store_unit;

  localparam int M = 10;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_fault;
  logic [M+1:0]  mem_address;
  logic [31:0]   mem_mask;
  logic          mem_wf;
  logic [31:0]   mem_w;
  logic [31:0]   mem_v;

  int checks   = 0;
  int failures = 0;
  int wf_total = 0;
  bit init_done = 1'b0;

  load_store_unit #(.M(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_mask(mem_mask), .mem_wf(mem_wf),
    .mem_w(mem_w), .mem_v(mem_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model: 4 KiB, big-endian word port ----------------
  logic [7:0] mem [0:4095];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (mem_wf) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_mask[31-8*i]) mem[12'(mem_address + 12'(i))] <= mem_w[31-8*i -: 8];
      end
    end
  end

  always_comb begin
    mem_v = {mem[mem_address], mem[12'(mem_address + 12'd1)],
             mem[12'(mem_address + 12'd2)], mem[12'(mem_address + 12'd3)]};
  end

  always @(negedge clk) if (mem_wf) wf_total <= wf_total + 1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_req(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_fault,
                         input logic [31:0] exp_mask, input int exp_wf);
    int  lat;
    bit  got;
    int  wf0;
    @(negedge clk);
    chk({nm, " req_ready"}, {31'h0, req_ready}, 32'h1);
    wf0          = wf_total;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({nm, " access resp_valid"}, {31'h0, resp_valid}, 32'h0);
    chk({nm, " mem_address"}, {20'h0, mem_address}, {20'h0, addr[11:0]});
    if (we && !exp_fault) chk({nm, " mem_mask"}, mem_mask, exp_mask);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      if (resp_valid) got = 1'b1;
    end
    chk({nm, " resp seen"}, {31'h0, got}, 32'h1);
    chk({nm, " latency"}, lat, 32'd1);
    chk({nm, " rdata"}, resp_rdata, exp_rdata);
    chk({nm, " fault"}, {31'h0, resp_fault}, {31'h0, exp_fault});
    @(posedge clk);
    #1;
    chk({nm, " resp drop"}, {31'h0, resp_valid}, 32'h0);
    chk({nm, " wf cycles"}, wf_total - wf0, exp_wf);
  endtask

  typedef struct {
    string       nm;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] mask;
    int          wf;
  } vec_t;

  vec_t vecs [0:15];

  initial begin
    logic [31:0] snap;
    int wf0;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    int wf0;

    vecs[0]  = '{"st_w_010",   1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 32'h0,        0, 32'hFFFFFFFF, 1};
    vecs[1]  = '{"ld_w_010",   0, 2'b10, 0, 32'h010, 32'h0,        32'hDEADBEEF, 0, 32'h0,        0};
    vecs[2]  = '{"st_b_011",   1, 2'b00, 0, 32'h011, 32'h000001A5, 32'h0,        0, 32'hFF000000, 1};
    vecs[3]  = '{"ld_w_010b",  0, 2'b10, 0, 32'h010, 32'h0,        32'hDEA5BEEF, 0, 32'h0,        0};
    vecs[4]  = '{"ld_bs_011",  0, 2'b00, 0, 32'h011, 32'h0,        32'hFFFFFFA5, 0, 32'h0,        0};
    vecs[5]  = '{"ld_bu_011",  0, 2'b00, 1, 32'h011, 32'h0,        32'h000000A5, 0, 32'h0,        0};
    vecs[6]  = '{"ld_hs_010",  0, 2'b01, 0, 32'h010, 32'h0,        32'hFFFFDEA5, 0, 32'h0,        0};
    vecs[7]  = '{"ld_w_ffe",   0, 2'b10, 0, 32'hFFE, 32'h0,        32'h0,        1, 32'h0,        0};
    vecs[8]  = '{"ld_b_1000",  0, 2'b00, 0, 32'h1000,32'h0,        32'h0,        1, 32'h0,        0};
    vecs[9]  = '{"ld_sz3_0",   0, 2'b11, 0, 32'h000, 32'h0,        32'h0,        1, 32'h0,        0};
    vecs[10] = '{"st_w_ffe",   1, 2'b10, 0, 32'hFFE, 32'h55555555, 32'h0,        1, 32'h0,        0};
    vecs[11] = '{"st_h_ffe",   1, 2'b01, 0, 32'hFFE, 32'h0000CAFE, 32'h0,        0, 32'hFFFF0000, 1};
    vecs[12] = '{"ld_w_ffc",   0, 2'b10, 0, 32'hFFC, 32'h0,        32'h0000CAFE, 0, 32'h0,        0};
    vecs[13] = '{"ld_b_top",   0, 2'b00, 0, 32'hFFFFFFFF, 32'h0,   32'h0,        1, 32'h0,        0};
`ifdef MISALIGN_TRAP_EN
    vecs[14] = '{"ld_hu_011",  0, 2'b01, 1, 32'h011, 32'h0,        32'h0,        1, 32'h0,        0};
    vecs[15] = '{"ld_w_011",   0, 2'b10, 0, 32'h011, 32'h0,        32'h0,        1, 32'h0,        0};
`else
    vecs[14] = '{"ld_hu_011",  0, 2'b01, 1, 32'h011, 32'h0,        32'h0000A5BE, 0, 32'h0,        0};
    vecs[15] = '{"ld_w_011",   0, 2'b10, 0, 32'h011, 32'h0,        32'hA5BEEF00, 0, 32'h0,        0};
`endif

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b1;
    init_done    = 1'b0;

    // Reset state.
    #1;
    chk("rst resp_valid",  {31'h0, resp_valid}, 32'h0);
    chk("rst resp_rdata",  resp_rdata, 32'h0);
    chk("rst resp_fault",  {31'h0, resp_fault}, 32'h0);
    chk("rst mem_wf",      {31'h0, mem_wf}, 32'h0);
    chk("rst mem_mask",    mem_mask, 32'h0);
    chk("rst mem_w",       mem_w, 32'h0);
    chk("rst mem_address", {20'h0, mem_address}, 32'h0);
    @(posedge clk);
    #1;
    init_done = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst req_ready", {31'h0, req_ready}, 32'h1);

    // Table-driven single transactions.
    for (int i = 0; i < 16; i++) begin
      run_req(vecs[i].nm, vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              vecs[i].rdata, vecs[i].fault, vecs[i].mask, vecs[i].wf);
    end

    // Response backpressure: held response, blocked second request.
    resp_ready = 1'b0;
    wf0 = wf_total;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h010; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stall resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("stall rdata", resp_rdata, 32'hDEA5BEEF);
    snap = resp_rdata;
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h010; req_wdata = 32'h11111111;
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("stall hold valid", {31'h0, resp_valid}, 32'h1);
      chk("stall hold rdata", resp_rdata, snap);
      chk("stall req_ready", {31'h0, req_ready}, 32'h0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall release", {31'h0, resp_valid}, 32'h0);
    chk("stall no write", wf_total - wf0, 32'd0);
    run_req("ld_w_010_after_stall", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'hDEA5BEEF, 1'b0, 32'h0, 0);

    // Reset in the middle of a store.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h020; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort mem_wf before", {31'h0, mem_wf}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort mem_wf",      {31'h0, mem_wf}, 32'h0);
    chk("abort mem_mask",    mem_mask, 32'h0);
    chk("abort mem_address", {20'h0, mem_address}, 32'h0);
    chk("abort resp_valid",  {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort req_ready", {31'h0, req_ready}, 32'h1);
    chk("abort rdata",     resp_rdata, 32'h0);
    run_req("ld_w_020", 1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 32'h00000000, 1'b0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
